exc_ctrl: RTL and testbench

Precise-exception controller at the MEM stage of the MIPS pipeline. It collects the exception flags decoded in ID (eret/syscall/break) and later flags (RI, overflow, address errors), plus synchronized hardware interrupts. It arbitrates them by priority and sequences the commit: CP0 write strobes, pipeline flush, and PC redirect. It holds the commit while the pipeline is stalled and drains the flush for a fixed window afterward.

---
 rtl/exc_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_exc_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
//
// Precise-exception controller sitting at the MEM stage of a MIPS pipeline.
// Gathers exception flags piped along with the MEM instruction and the
// synchronized hardware interrupts, picks one winner by fixed priority, and
// sequences its commit: CP0 write strobes, a pipeline flush and a PC redirect.
// A commit is held off while the pipeline is stalled. Once it is committed,
// flush stays high for a fixed drain window.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_valid             MEM holds a real instruction (not a bubble)
//   mem_pc                PC of the MEM instruction
//   mem_delayslot         MEM instruction sits in a branch delay slot
//   mem_addr              data access address of the MEM instruction
//   eret/syscall/break    flags decoded in ID
//   ri_flag, ov_flag      reserved instruction, arithmetic overflow
//   adel_if/adel_d/ades_d fetch load error, data load error, data store error
//   hw_int                asynchronous hardware interrupt lines
//   cp0_status            Status (IE=0, EXL=1, IM=15:8)
//   cp0_cause_ip          software interrupt bits Cause[9:8]
//   cp0_epc               current EPC, the ERET return target
//   stall                 pipeline stalled, MEM contents frozen
//   flush                 kill IF..MEM
//   redirect_valid/pc     load the next PC from redirect_pc
//   epc_we/wdata          EPC write
//   cause_we/exccode/bd   Cause.ExcCode and Cause.BD write
//   badvaddr_we/wdata     BadVAddr write (address errors only)
//   exl_set, exl_clr      Status.EXL set and clear strobes
//   hw_int_sync           synchronized interrupt lines for Cause.IP[7:2]
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic [31:0] mem_addr,
  input  logic        eret_flag,
  input  logic        syscall_flag,
  input  logic        break_flag,
  input  logic        ri_flag,
  input  logic        ov_flag,
  input  logic        adel_if,
  input  logic        adel_d,
  input  logic        ades_d,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [1:0]  cp0_cause_ip,
  input  logic [31:0] cp0_epc,
  input  logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        epc_we,
  output logic [31:0] epc_wdata,
  output logic        cause_we,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_wdata,
  output logic        exl_set,
  output logic        exl_clr,
  output logic [5:0]  hw_int_sync
);

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // The drain counter holds the number of DRAIN cycles still to go after the
  // current one, so it only needs to reach FLUSH_CYCLES-2.
  localparam int unsigned      CW         = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]    DRAIN_LAST = CW'(FLUSH_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } state_t;

  // Everything needed to commit one event after MEM has moved on.
  typedef struct packed {
    logic        is_eret;
    logic [4:0]  exccode;
    logic        bad_we;
    logic [31:0] badvaddr;
    logic [31:0] epc;
    logic        bd;
  } evt_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  evt_t           held_q, held_d;
  evt_t           live, cevt;
  logic           live_hit;
  logic           commit;
  logic           int_req;
  logic [5:0]     sync_q;

  // Only IE, EXL and IM take part in the interrupt decision.
  logic unused_status;
  assign unused_status = ^{cp0_status[31:16], cp0_status[7:2]};

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      hw_int_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments so the second flop takes the first
      // flop's pre-edge value; blocking would collapse the chain to one stage.
      sync_q      <= hw_int;
      hw_int_sync <= sync_q;
    end
  end

  assign int_req = cp0_status[0] & ~cp0_status[1]
                 & (|({hw_int_sync, cp0_cause_ip} & cp0_status[15:8]));

  // Priority pick among the events raised by the current MEM instruction.
  always_comb begin
    live     = '0;
    live_hit = 1'b0;
    if (mem_valid) begin
      live_hit = 1'b1;
      live.epc = mem_delayslot ? (mem_pc - 32'd4) : mem_pc;
      live.bd  = mem_delayslot;
      if (int_req) begin
        live.exccode = EXC_INT;
      end else if (adel_if) begin
        live.exccode  = EXC_ADEL;
        live.bad_we   = 1'b1;
        live.badvaddr = mem_pc;
      end else if (ri_flag) begin
        live.exccode = EXC_RI;
      end else if (ov_flag) begin
        live.exccode = EXC_OV;
      end else if (syscall_flag) begin
        live.exccode = EXC_SYS;
      end else if (break_flag) begin
        live.exccode = EXC_BP;
      end else if (adel_d) begin
        live.exccode  = EXC_ADEL;
        live.bad_we   = 1'b1;
        live.badvaddr = mem_addr;
      end else if (ades_d) begin
        live.exccode  = EXC_ADES;
        live.bad_we   = 1'b1;
        live.badvaddr = mem_addr;
      end else if (eret_flag) begin
        live.is_eret = 1'b1;
      end else begin
        live_hit = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the held event is a handful of plain registers, not a memory
      // array, so it is reset along with the FSM.
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    commit  = 1'b0;
    cevt    = held_q;

    unique case (state_q)
      IDLE: begin
        // Reset is folded in so that outputs are quiet while it is asserted.
        if (live_hit && rst_n) begin
          if (stall) begin
            held_d  = live;
            state_d = HOLD;
          end else begin
            commit = 1'b1;
            cevt   = live;
          end
        end
      end
      HOLD: begin
        // New flags and interrupts are ignored; the latched event commits.
        if (!stall) commit = 1'b1;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = DRAIN;
        cnt_d   = DRAIN_LAST;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Strobes fire only in the commit cycle; data buses read zero otherwise.
  assign flush          = commit | (state_q == DRAIN);
  assign redirect_valid = commit;
  assign redirect_pc    = !commit      ? '0
                        : cevt.is_eret ? cp0_epc
                        :                EXC_VECTOR;
  assign epc_we         = commit & ~cevt.is_eret;
  assign epc_wdata      = epc_we ? cevt.epc : '0;
  assign cause_we       = epc_we;
  assign cause_exccode  = epc_we ? cevt.exccode : '0;
  assign cause_bd       = epc_we & cevt.bd;
  assign badvaddr_we    = epc_we & cevt.bad_we;
  assign badvaddr_wdata = badvaddr_we ? cevt.badvaddr : '0;
  assign exl_set        = epc_we;
  assign exl_clr        = commit & cevt.is_eret;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
//
// Bench for exc_ctrl: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the controller.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_delayslot;
  logic [31:0] mem_pc, mem_addr;
  logic        eret_flag, syscall_flag, break_flag, ri_flag, ov_flag;
  logic        adel_if, adel_d, ades_d;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status, cp0_epc;
  logic [1:0]  cp0_cause_ip;
  logic        stall;
  logic        flush, redirect_valid, epc_we, cause_we, cause_bd;
  logic        badvaddr_we, exl_set, exl_clr;
  logic [31:0] redirect_pc, epc_wdata, badvaddr_wdata;
  logic [4:0]  cause_exccode;
  logic [5:0]  hw_int_sync;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_delayslot(mem_delayslot),
    .mem_addr(mem_addr),
    .eret_flag(eret_flag), .syscall_flag(syscall_flag), .break_flag(break_flag),
    .ri_flag(ri_flag), .ov_flag(ov_flag),
    .adel_if(adel_if), .adel_d(adel_d), .ades_d(ades_d),
    .hw_int(hw_int), .cp0_status(cp0_status), .cp0_cause_ip(cp0_cause_ip),
    .cp0_epc(cp0_epc), .stall(stall),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc_we(epc_we), .epc_wdata(epc_wdata),
    .cause_we(cause_we), .cause_exccode(cause_exccode), .cause_bd(cause_bd),
    .badvaddr_we(badvaddr_we), .badvaddr_wdata(badvaddr_wdata),
    .exl_set(exl_set), .exl_clr(exl_clr), .hw_int_sync(hw_int_sync)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a record of what one commit writes, a count of flush
  // cycles still owed, an optionally parked event, and the interrupt lines as
  // seen two edges late.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    bit        is_eret;
    bit [4:0]  code;
    bit        bad;
    bit [31:0] badv;
    bit [31:0] epc;
    bit        bd;
  } rec_t;

  int       m_flush_left = 0;
  bit       m_held = 1'b0;
  rec_t     m_rec = '0;
  bit [5:0] m_s1 = '0, m_sync = '0;
  bit       d_commit = 1'b0, d_latch = 1'b0;
  rec_t     d_rec = '0;

  task automatic model_clear();
    m_flush_left = 0;
    m_held       = 1'b0;
    m_rec        = '0;
    m_s1         = '0;
    m_sync       = '0;
    d_commit     = 1'b0;
    d_latch      = 1'b0;
  endtask

  // Highest-priority event raised by the current MEM instruction, if any.
  function automatic bit find_event(output rec_t r);
    bit [7:0] ip;
    bit       irq;
    bit       fl[8];
    bit [4:0] codes[8];
    r   = '0;
    ip  = {m_sync, cp0_cause_ip};
    irq = cp0_status[0] && !cp0_status[1] && ((ip & cp0_status[15:8]) != 8'd0);
    if (!mem_valid) return 1'b0;
    r.epc = mem_delayslot ? mem_pc - 32'd4 : mem_pc;
    r.bd  = mem_delayslot;
    if (irq) return 1'b1;
    fl    = '{adel_if, ri_flag, ov_flag, syscall_flag, break_flag, adel_d, ades_d, eret_flag};
    codes = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5, 5'd0};
    for (int i = 0; i < 8; i++) begin
      if (fl[i]) begin
        r.code    = codes[i];
        r.bad     = (i == 0) || (i == 5) || (i == 6);
        r.badv    = (i == 0) ? mem_pc : mem_addr;
        r.is_eret = (i == 7);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic eval_and_check();
    rec_t live, c;
    bit   hit, e_flush, e_commit, e_exc;
    e_flush  = 1'b0;
    e_commit = 1'b0;
    c        = '0;
    d_latch  = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else if (m_flush_left > 0) begin
      e_flush = 1'b1;
    end else if (m_held) begin
      if (!stall) begin
        e_commit = 1'b1;
        c        = m_rec;
      end
    end else begin
      hit = find_event(live);
      if (hit && stall) begin
        d_latch = 1'b1;
        d_rec   = live;
      end else if (hit) begin
        e_commit = 1'b1;
        c        = live;
      end
    end
    d_commit = e_commit;
    if (e_commit) e_flush = 1'b1;
    e_exc = e_commit && !c.is_eret;

    check("flush", flush, e_flush);
    check("redirect_valid", redirect_valid, e_commit);
    if (e_commit) check("redirect_pc", redirect_pc, c.is_eret ? cp0_epc : VEC);
    check("epc_we", epc_we, e_exc);
    check("cause_we", cause_we, e_exc);
    check("exl_set", exl_set, e_exc);
    check("exl_clr", exl_clr, e_commit && c.is_eret);
    check("badvaddr_we", badvaddr_we, e_exc && c.bad);
    if (e_exc) begin
      check("epc_wdata", epc_wdata, c.epc);
      check("cause_exccode", cause_exccode, c.code);
      check("cause_bd", cause_bd, c.bd);
      if (c.bad) check("badvaddr_wdata", badvaddr_wdata, c.badv);
    end
    check("hw_int_sync", hw_int_sync, m_sync);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      return;
    end
    m_sync = m_s1;
    m_s1   = hw_int;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (d_commit) begin
      m_flush_left = FC - 1;
      m_held       = 1'b0;
    end else if (d_latch) begin
      m_held = 1'b1;
      m_rec  = d_rec;
    end
  endtask

  task automatic settle();
    #3;
    eval_and_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  // Clears per-instruction inputs; CP0 state and interrupt lines are kept.
  task automatic idle();
    mem_valid     = 1'b0;
    mem_delayslot = 1'b0;
    mem_pc        = 32'h0;
    mem_addr      = 32'h0;
    eret_flag     = 1'b0;
    syscall_flag  = 1'b0;
    break_flag    = 1'b0;
    ri_flag       = 1'b0;
    ov_flag       = 1'b0;
    adel_if       = 1'b0;
    adel_d        = 1'b0;
    ades_d        = 1'b0;
    stall         = 1'b0;
  endtask

  function automatic bit one_in(input int n);
    return $urandom_range(n - 1, 0) == 0;
  endfunction

  initial begin
    rst_n        = 1'b0;
    hw_int       = '0;
    cp0_status   = '0;
    cp0_cause_ip = '0;
    cp0_epc      = '0;
    idle();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // syscall, not in a delay slot
    mem_valid    = 1'b1;
    mem_pc       = 32'h8000_1000;
    syscall_flag = 1'b1;
    settle();
    check("sys_epc", epc_wdata, 32'h8000_1000);
    check("sys_code", cause_exccode, 32'd8);
    check("sys_exl_set", exl_set, 32'd1);
    check("sys_vector", redirect_pc, VEC);
    check("sys_flush_c0", flush, 32'd1);
    tick();
    idle();
    settle();
    check("sys_flush_c1", flush, 32'd1);
    check("sys_no_redirect_c1", redirect_valid, 32'd0);
    tick();
    settle();
    check("sys_flush_c2", flush, 32'd0);
    tick();

    // overflow in a delay slot
    mem_valid     = 1'b1;
    mem_delayslot = 1'b1;
    mem_pc        = 32'h8000_0008;
    ov_flag       = 1'b1;
    settle();
    check("ov_epc", epc_wdata, 32'h8000_0004);
    check("ov_bd", cause_bd, 32'd1);
    check("ov_code", cause_exccode, 32'd12);
    tick();
    idle();
    cycle();
    cycle();

    // hardware interrupt 0 through the synchronizer, IE=1, EXL=0, IM[10]=1
    cp0_status = 32'h0000_0401;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0100;
    hw_int     = 6'b00_0001;
    settle();
    check("int_edge0", redirect_valid, 32'd0);
    tick();
    settle();
    check("int_edge1", redirect_valid, 32'd0);
    tick();
    settle();
    check("int_commit", redirect_valid, 32'd1);
    check("int_code", cause_exccode, 32'd0);
    check("int_epc", epc_wdata, 32'h8000_0100);
    tick();
    idle();
    hw_int     = '0;
    cp0_status = 32'h0000_0403;
    repeat (3) cycle();
    mem_valid = 1'b1;
    hw_int    = 6'b00_0001;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("int_exl_masked", redirect_valid, 32'd0);
      tick();
    end

    // RI together with a pending interrupt: the interrupt wins
    cp0_status = 32'h0000_0401;
    mem_pc     = 32'h8000_0200;
    ri_flag    = 1'b1;
    settle();
    check("ri_int_code", cause_exccode, 32'd0);
    check("ri_int_epc", epc_wdata, 32'h8000_0200);
    tick();
    idle();
    cycle();
    cp0_status = 32'h0;
    mem_valid  = 1'b1;
    adel_d     = 1'b1;
    mem_addr   = 32'h0000_1003;
    settle();
    check("adel_d_code", cause_exccode, 32'd4);
    check("adel_d_bad_we", badvaddr_we, 32'd1);
    check("adel_d_badv", badvaddr_wdata, 32'h0000_1003);
    tick();
    idle();
    cycle();

    // break held across a 3-cycle stall; an ades_d pulse in between is ignored
    hw_int     = '0;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0300;
    break_flag = 1'b1;
    stall      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_stall_epc_we", epc_we, 32'd0);
      check("bp_stall_flush", flush, 32'd0);
      tick();
      break_flag = 1'b0;
      ades_d     = (i == 0);
      mem_addr   = 32'h0000_0bad;
    end
    idle();
    settle();
    check("bp_commit_code", cause_exccode, 32'd9);
    check("bp_commit_epc", epc_wdata, 32'h8000_0300);
    check("bp_no_badv", badvaddr_we, 32'd0);
    tick();
    idle();
    cycle();

    // ERET, then reset asserted in the middle of the drain
    mem_valid = 1'b1;
    eret_flag = 1'b1;
    cp0_epc   = 32'h8000_2000;
    settle();
    check("eret_exl_clr", exl_clr, 32'd1);
    check("eret_target", redirect_pc, 32'h8000_2000);
    check("eret_no_epc_we", epc_we, 32'd0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("drain_async_rst_flush", flush, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      mem_valid     = !one_in(6);
      mem_pc        = {$urandom} & 32'hFFFF_FFFC;
      mem_delayslot = one_in(4);
      mem_addr      = $urandom;
      eret_flag     = one_in(14);
      syscall_flag  = one_in(14);
      break_flag    = one_in(14);
      ri_flag       = one_in(14);
      ov_flag       = one_in(14);
      adel_if       = one_in(14);
      adel_d        = one_in(14);
      ades_d        = one_in(14);
      stall         = one_in(4);
      cp0_epc       = $urandom;
      if (one_in(8))  hw_int[$urandom_range(5, 0)] ^= 1'b1;
      if (one_in(16)) cp0_status = {$urandom} & 32'h0000_FF03;
      if (one_in(24)) cp0_cause_ip = 2'($urandom);
      rst_n = !one_in(200);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
